// File: rtl/ex_operand_stage.sv
// Execute-side operand stage: single-entry skid register between decode and ALU
// with MEM/WB forwarding, register-file write-through on accept, and WB refresh while stalled.
module ex_operand_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        InValid,
  output logic        InReady,
  input  logic [31:0] RD1,
  input  logic [31:0] RD2,
  input  logic [31:0] Imm,
  input  logic [31:0] PC,
  input  logic [4:0]  Rs1,
  input  logic [4:0]  Rs2,
  input  logic [4:0]  Rd,
  input  logic        ALUSrcA,
  input  logic        ALUSrcB,
  input  logic [3:0]  ALUControlIn,
  input  logic        RegWriteIn,
  input  logic        Flush,
  input  logic        MemRegWrite,
  input  logic [4:0]  MemRd,
  input  logic [31:0] MemResult,
  input  logic        WbRegWrite,
  input  logic [4:0]  WbRd,
  input  logic [31:0] WbResult,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [3:0]  ALUControl,
  output logic [4:0]  RdOut,
  output logic        RegWriteOut,
  output logic [31:0] StoreData
);

  logic        r_valid;
  logic [31:0] r_rd1, r_rd2, r_imm, r_pc;
  logic [4:0]  r_rs1, r_rs2, r_rd;
  logic        r_srca, r_srcb, r_regwrite;
  logic [3:0]  r_aluctl;

  logic        w_accept;
  logic        w_hold;
  logic        w_wb_in1, w_wb_in2;
  logic        w_wb_st1, w_wb_st2;
  logic [31:0] w_src1, w_src2;

  assign InReady  = !r_valid || OutReady;
  assign w_accept = InValid && InReady && !Flush;
  assign w_hold   = r_valid && !OutReady;

  // x0 is excluded from every WB match, both for incoming and stored indices
  assign w_wb_in1 = WbRegWrite && (WbRd != '0) && (WbRd == Rs1);
  assign w_wb_in2 = WbRegWrite && (WbRd != '0) && (WbRd == Rs2);
  assign w_wb_st1 = WbRegWrite && (WbRd != '0) && (WbRd == r_rs1);
  assign w_wb_st2 = WbRegWrite && (WbRd != '0) && (WbRd == r_rs2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_pc       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_srca     <= 1'b0;
      r_srcb     <= 1'b0;
      r_aluctl   <= '0;
      r_regwrite <= 1'b0;
    end else if (Flush) begin
      r_valid    <= 1'b0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_pc       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_srca     <= 1'b0;
      r_srcb     <= 1'b0;
      r_aluctl   <= '0;
      r_regwrite <= 1'b0;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_rd1      <= w_wb_in1 ? WbResult : RD1;
      r_rd2      <= w_wb_in2 ? WbResult : RD2;
      r_imm      <= Imm;
      r_pc       <= PC;
      r_rs1      <= Rs1;
      r_rs2      <= Rs2;
      r_rd       <= Rd;
      r_srca     <= ALUSrcA;
      r_srcb     <= ALUSrcB;
      r_aluctl   <= ALUControlIn;
      r_regwrite <= RegWriteIn;
    end else if (w_hold) begin
      // WB retires while we stall: capture it now, it will not be forwardable later
      if (w_wb_st1) r_rd1 <= WbResult;
      if (w_wb_st2) r_rd2 <= WbResult;
    end else if (r_valid && OutReady) begin
      r_valid <= 1'b0;
    end
  end

  always_comb begin
    w_src1 = r_rd1;
    if ((r_rs1 != '0) && MemRegWrite && (MemRd == r_rs1))
      w_src1 = MemResult;
    else if ((r_rs1 != '0) && WbRegWrite && (WbRd == r_rs1))
      w_src1 = WbResult;
  end

  always_comb begin
    w_src2 = r_rd2;
    if ((r_rs2 != '0) && MemRegWrite && (MemRd == r_rs2))
      w_src2 = MemResult;
    else if ((r_rs2 != '0) && WbRegWrite && (WbRd == r_rs2))
      w_src2 = WbResult;
  end

  assign OutValid    = r_valid;
  assign A           = r_srca ? r_pc  : w_src1;
  assign B           = r_srcb ? r_imm : w_src2;
  assign StoreData   = w_src2;
  assign ALUControl  = r_aluctl;
  assign RdOut       = r_rd;
  assign RegWriteOut = r_regwrite && r_valid;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: handshake, forwarding, refresh, flush and async reset.
module tb_ex_operand_stage;

  logic        clk, rst_n;
  logic        InValid, InReady;
  logic [31:0] RD1, RD2, Imm, PC;
  logic [4:0]  Rs1, Rs2, Rd;
  logic        ALUSrcA, ALUSrcB;
  logic [3:0]  ALUControlIn;
  logic        RegWriteIn, Flush;
  logic        MemRegWrite;
  logic [4:0]  MemRd;
  logic [31:0] MemResult;
  logic        WbRegWrite;
  logic [4:0]  WbRd;
  logic [31:0] WbResult;
  logic        OutValid, OutReady;
  logic [31:0] A, B, StoreData;
  logic [3:0]  ALUControl;
  logic [4:0]  RdOut;
  logic        RegWriteOut;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .InValid(InValid), .InReady(InReady),
    .RD1(RD1), .RD2(RD2), .Imm(Imm), .PC(PC),
    .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControlIn(ALUControlIn), .RegWriteIn(RegWriteIn), .Flush(Flush),
    .MemRegWrite(MemRegWrite), .MemRd(MemRd), .MemResult(MemResult),
    .WbRegWrite(WbRegWrite), .WbRd(WbRd), .WbResult(WbResult),
    .OutValid(OutValid), .OutReady(OutReady),
    .A(A), .B(B), .ALUControl(ALUControl),
    .RdOut(RdOut), .RegWriteOut(RegWriteOut), .StoreData(StoreData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    MemRegWrite = 1'b0; MemRd = '0; MemResult = '0;
    WbRegWrite  = 1'b0; WbRd  = '0; WbResult  = '0;
  endtask

  // Presents one instruction for a single edge, then leaves the stage stalled or draining.
  task automatic issue(input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic sa, input logic sb, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [3:0] op, input logic rw,
                       input logic ready_after);
    RD1 = rd1; RD2 = rd2; Rs1 = rs1; Rs2 = rs2; Rd = rd;
    ALUSrcA = sa; ALUSrcB = sb; PC = pc; Imm = imm;
    ALUControlIn = op; RegWriteIn = rw;
    InValid = 1'b1; OutReady = 1'b1;
    tick();
    InValid = 1'b0; OutReady = ready_after;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; InValid = 1'b0; OutReady = 1'b0; Flush = 1'b0;
    RD1 = '0; RD2 = '0; Imm = '0; PC = '0; Rs1 = '0; Rs2 = '0; Rd = '0;
    ALUSrcA = 1'b0; ALUSrcB = 1'b0; ALUControlIn = '0; RegWriteIn = 1'b0;
    clear_fwd();

    #3;
    check("rst_outvalid", {31'b0, OutValid}, 32'd0);
    check("rst_inready", {31'b0, InReady}, 32'd1);
    check("rst_A", A, 32'd0);
    check("rst_B", B, 32'd0);
    check("rst_store", StoreData, 32'd0);
    check("rst_regwrite", {31'b0, RegWriteOut}, 32'd0);
    #9 rst_n = 1'b1;

    // basic pass-through
    issue(32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b1);
    check("basic_outvalid", {31'b0, OutValid}, 32'd1);
    check("basic_A", A, 32'd5);
    check("basic_B", B, 32'd7);
    check("basic_aluctl", {28'b0, ALUControl}, 32'd0);
    check("basic_rdout", {27'b0, RdOut}, 32'd3);
    check("basic_regwrite", {31'b0, RegWriteOut}, 32'd1);
    check("basic_store", StoreData, 32'd7);
    tick();
    check("drain_outvalid", {31'b0, OutValid}, 32'd0);
    check("drain_regwrite", {31'b0, RegWriteOut}, 32'd0);

    // PC / Imm operand selects
    issue(32'h1, 32'h55, 5'd5, 5'd6, 5'd9, 1'b1, 1'b1, 32'h100, 32'h20, 4'hA, 1'b0, 1'b0);
    check("mux_A_pc", A, 32'h100);
    check("mux_B_imm", B, 32'h20);
    check("mux_store", StoreData, 32'h55);
    check("mux_aluctl", {28'b0, ALUControl}, 32'hA);
    check("stall_inready", {31'b0, InReady}, 32'd0);

    // forwarding priority MEM over WB
    issue(32'h11, 32'h22, 5'd3, 5'd8, 5'd1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h1, 1'b1, 1'b0);
    MemRegWrite = 1'b1; MemRd = 5'd3; MemResult = 32'hAA;
    WbRegWrite  = 1'b1; WbRd  = 5'd3; WbResult  = 32'hBB;
    #1 check("fwd_mem_prio", A, 32'hAA);
    MemRegWrite = 1'b0;
    #1 check("fwd_wb", A, 32'hBB);
    clear_fwd();
    #1 check("fwd_none", A, 32'h11);

    // stall refresh of RD2
    issue(32'h0, 32'h9, 5'd10, 5'd4, 5'd2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h2, 1'b0, 1'b0);
    check("refresh_pre_B", B, 32'h9);
    WbRegWrite = 1'b1; WbRd = 5'd4; WbResult = 32'h1234;
    tick();
    clear_fwd();
    OutReady = 1'b1;
    #1;
    check("refresh_held", {31'b0, OutValid}, 32'd1);
    check("refresh_B", B, 32'h1234);
    check("refresh_store", StoreData, 32'h1234);
    tick();

    // write-through on accept
    WbRegWrite = 1'b1; WbRd = 5'd7; WbResult = 32'h777;
    issue(32'h1, 32'h2, 5'd7, 5'd12, 5'd4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h3, 1'b1, 1'b1);
    clear_fwd();
    #1 check("wthru_A", A, 32'h777);
    check("wthru_B", B, 32'h2);

    // x0 is never forwarded nor written through
    WbRegWrite = 1'b1; WbRd = 5'd0; WbResult = 32'hEE;
    issue(32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    MemRegWrite = 1'b1; MemRd = 5'd0; MemResult = 32'hFF;
    #1 check("x0_A", A, 32'h0);
    check("x0_B", B, 32'h0);
    clear_fwd();

    // flush beats a simultaneous accept
    RD1 = 32'h33; Rs1 = 5'd1; RegWriteIn = 1'b1; Rd = 5'd5;
    Flush = 1'b1; InValid = 1'b1; OutReady = 1'b1;
    tick();
    Flush = 1'b0; InValid = 1'b0;
    #1;
    check("flush_outvalid", {31'b0, OutValid}, 32'd0);
    check("flush_regwrite", {31'b0, RegWriteOut}, 32'd0);
    check("flush_inready", {31'b0, InReady}, 32'd1);
    check("flush_A", A, 32'h0);
    check("flush_rdout", {27'b0, RdOut}, 32'd0);

    // asynchronous reset between edges
    issue(32'h42, 32'h43, 5'd1, 5'd2, 5'd6, 1'b0, 1'b0, 32'h0, 32'h0, 4'h7, 1'b1, 1'b0);
    check("pre_rst_outvalid", {31'b0, OutValid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_outvalid", {31'b0, OutValid}, 32'd0);
    check("arst_A", A, 32'h0);
    check("arst_B", B, 32'h0);
    check("arst_aluctl", {28'b0, ALUControl}, 32'h0);
    check("arst_regwrite", {31'b0, RegWriteOut}, 32'd0);
    check("arst_inready", {31'b0, InReady}, 32'd1);
    #1 rst_n = 1'b1;
    issue(32'h99, 32'h98, 5'd1, 5'd2, 5'd6, 1'b0, 1'b0, 32'h0, 32'h0, 4'h4, 1'b1, 1'b1);
    check("post_rst_outvalid", {31'b0, OutValid}, 32'd1);
    check("post_rst_A", A, 32'h99);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 Parameters: none; data width fixed at 32 bits, register index width fixed at 5 bits.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 InValid  input  1  decode stage presents an instruction.
REQ-005 InReady  output  1  stage can accept an instruction this cycle.
REQ-006 RD1, RD2  input  32  register-file read data for Rs1, Rs2.
REQ-007 Imm, PC  input  32  decoded immediate and instruction address.
REQ-008 Rs1, Rs2, Rd  input  5  source and destination register indices.
REQ-009 ALUSrcA  input  1  1 selects PC as ALU operand A, 0 selects forwarded Rs1.
REQ-010 ALUSrcB  input  1  1 selects Imm as ALU operand B, 0 selects forwarded Rs2.
REQ-011 ALUControlIn  input  4  ALU operation code, passed through unchanged.
REQ-012 RegWriteIn  input  1  instruction writes Rd.
REQ-013 Flush  input  1  kill the held instruction (branch/jump redirect).
REQ-014 MemRegWrite  input  1; MemRd  input  5; MemResult  input  32: MEM-stage forwarding source.
REQ-015 WbRegWrite  input  1; WbRd  input  5; WbResult  input  32: WB-stage forwarding source.
REQ-016 OutValid  output  1; OutReady  input  1: execute-side handshake.
REQ-017 A, B  output  32: ALU operands.
REQ-018 ALUControl  output  4: ALU operation code.
REQ-019 RdOut  output  5; RegWriteOut  output  1; StoreData  output  32: values carried to the next stage.

Function
REQ-020 Storage SHALL be a single-entry register holding RD1, RD2, Imm, PC, Rs1, Rs2, Rd, ALUSrcA, ALUSrcB, ALUControlIn and RegWriteIn.
REQ-021 InReady SHALL equal (!OutValid || OutReady), combinationally.
REQ-022 Accept SHALL occur when InValid && InReady && !Flush. On accept, the entry is loaded and OutValid is 1 at the next edge (latency 1 cycle).
REQ-023 When OutValid && OutReady && no accept, OutValid SHALL go to 0 at the next edge.
REQ-024 When OutValid && !OutReady, the entry SHALL hold, except for the refresh defined in REQ-028.
REQ-025 Flush SHALL take priority over accept: at the next edge OutValid=0 and every stored field=0; any incoming instruction in that cycle is dropped.
REQ-026 Forwarded src1 SHALL be selected combinationally from the stored Rs1 as follows:
- if Rs1!=0 && MemRegWrite && MemRd==Rs1, then MemResult;
- else if Rs1!=0 && WbRegWrite && WbRd==Rs1, then WbResult;
- else stored RD1.
Forwarded src2 SHALL be selected the same way from Rs2, RD2 and the same sources.
REQ-027 On accept, if WbRegWrite && WbRd!=0 && WbRd equals the incoming Rs1 (or Rs2), WbResult SHALL be stored in place of RD1 (or RD2). This covers the register-file write-through case.
REQ-028 While the entry is held, if WbRegWrite && WbRd!=0 && WbRd equals the stored Rs1 (or Rs2), the stored RD1 (or RD2) SHALL be overwritten with WbResult at the edge.
REQ-029 Index x0 SHALL never be forwarded or refreshed.
REQ-030 Outputs SHALL be driven as follows:
- A = ALUSrcA ? stored PC : src1;
- B = ALUSrcB ? stored Imm : src2;
- StoreData = src2;
- ALUControl and RdOut = stored values;
- RegWriteOut = stored RegWriteIn && OutValid.
REQ-031 No arithmetic SHALL be performed in this block; all widths pass through unmodified.

Reset
REQ-032 rst_n low SHALL immediately (asynchronously) set OutValid=0 and every stored field=0. Resulting outputs: A=0, B=0, ALUControl=4'b0000, RdOut=0, RegWriteOut=0, StoreData=0, InReady=1.
REQ-033 Reset asserted mid-operation SHALL discard the held instruction. The first accept is possible on the first rising edge with rst_n high.

Verification
REQ-034 Basic pass: RD1=5, RD2=7, ALUSrcA=0, ALUSrcB=0, ALUControlIn=0000, InValid=1, OutReady=1. Next cycle: OutValid=1, A=5, B=7, ALUControl=0000.
REQ-035 Forward priority: stored Rs1=3; MemRegWrite=1, MemRd=3, MemResult=0xAA; WbRegWrite=1, WbRd=3, WbResult=0xBB. Required: A=0xAA. With MemRegWrite=0, A=0xBB.
REQ-036 Stall refresh: entry holds Rs2=4, OutReady=0; one-cycle WB write of x4=0x1234; then OutReady=1 with no forwarding. Required: B=0x1234 and StoreData=0x1234.
REQ-037 x0 rule: Rs1=0, RD1=0, MemRegWrite=1, MemRd=0, MemResult=0xFF. Required: A=0.
REQ-038 Flush vs accept: Flush=1 together with InValid=1. Next cycle: OutValid=0, RegWriteOut=0, InReady=1.
REQ-039 Async reset: rst_n pulled low between edges while OutValid=1. Outputs go to reset values immediately, without waiting for clk.
